mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 22, byte-address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 Parameter MAX_OUTSTANDING, default 2, range 1..4; maximum granted-but-unanswered transactions.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 instr_req_i / instr_addr_i  in  1 / ADDR_WIDTH  read-only instruction port request.
REQ-007 instr_gnt_o / instr_rvalid_o / instr_rdata_o  out  1 / 1 / DATA_WIDTH  instruction grant and response.
REQ-008 data_req_i / data_addr_i / data_we_i / data_be_i / data_wdata_i  in  1 / ADDR_WIDTH / 1 / 4 / DATA_WIDTH  data port request.
REQ-009 data_gnt_o / data_rvalid_o / data_rdata_o  out  1 / 1 / DATA_WIDTH  data grant and response.
REQ-010 mem_req_o / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  out  1 / ADDR_WIDTH / 1 / 4 / DATA_WIDTH  single-port memory request.
REQ-011 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1 / 1 / DATA_WIDTH  memory grant and in-order response.

Function
REQ-012 Protocol on all ports: requester holds req and payload stable until gnt; transfer occurs in a cycle with req=1 and gnt=1; responses return in issue order, any latency >=1 cycle.
REQ-013 Arbitration is round-robin: with both requests, the port not granted last wins; single request wins unconditionally.
REQ-014 last_granted register updates only on an accepted transfer (mem_req_o & mem_gnt_i); reset value = instr, so data wins the first tie.
REQ-015 Selection and mem_* payload mux are combinational; mem_req_o = (instr_req_i | data_req_i) & ~full.
REQ-016 For instruction transfers mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-017 instr_gnt_o / data_gnt_o = mem_gnt_i & mem_req_o & (port selected); never both 1 in the same cycle.
REQ-018 Each accepted transfer pushes a 1-bit source ID (0=instr, 1=data) into an ID FIFO of depth MAX_OUTSTANDING.
REQ-019 mem_rvalid_i pops the FIFO head; rvalid_o of the head's port asserts in the same cycle, combinationally; other port rvalid_o=0.
REQ-020 instr_rdata_o and data_rdata_o both equal mem_rdata_i (qualified only by respective rvalid_o).
REQ-021 Full (count=MAX_OUTSTANDING): mem_req_o=0 and no grants, even if a pop occurs in the same cycle.
REQ-022 Simultaneous push and pop when not full: count unchanged, new ID enters behind remaining entries.
REQ-023 mem_rvalid_i with FIFO empty: ignored, no rvalid_o asserted, count stays 0.
REQ-024 Pointers wrap modulo MAX_OUTSTANDING; count width ceil(log2(MAX_OUTSTANDING+1)).
REQ-025 Write transfers also receive a response (mem_rvalid_i) routed to data_rvalid_o.

Reset
REQ-026 While rst_i=1: FIFO count and pointers 0, last_granted=instr; all gnt_o, rvalid_o, mem_req_o = 0.
REQ-027 Reset mid-operation discards outstanding IDs; later mem_rvalid_i for discarded transfers is ignored per REQ-023.
REQ-028 Registered state updates resume on the first rising edge after rst_i deasserts.

Verification
REQ-029 Both ports request, mem_gnt_i=1 always, 1-cycle memory: grants alternate data, instr, data, instr...; rvalids follow the same order one cycle later.
REQ-030 MAX_OUTSTANDING=2, mem_rvalid_i held 0, instr_req_i=1: two grants then mem_req_o=0 and no grant until a rvalid arrives; rvalid cycle itself still no grant.
REQ-031 Data write addr 0x100, be 4'h3, wdata 0xDEADBEEF: mem_* carry exactly these values in the grant cycle; response asserts data_rvalid_o only.
REQ-032 Instr issued at t, data at t+1, memory latency 3: instr_rvalid_o at t+3 with mem_rdata_i, data_rvalid_o at t+4.
REQ-033 rst_i pulsed with 2 outstanding, then mem_rvalid_i=1 twice: no rvalid_o asserted, count remains 0, next tie grants data.
REQ-034 mem_gnt_i=0 for 5 cycles with instr_req_i=1: mem_req_o=1, payload stable, instr_gnt_o=0, FIFO count unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port (instruction / data) round-robin arbiter in front of a single-port
//   memory with pipelined, in-order responses. The arbiter tracks which port
//   owns each granted-but-unanswered transfer in a small ID FIFO and steers
//   every memory response back to its owner.
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   instr_req_i / instr_addr_i        read-only instruction request
//   instr_gnt_o / instr_rvalid_o /
//   instr_rdata_o                     instruction grant and response
//   data_req_i / data_addr_i /
//   data_we_i / data_be_i /
//   data_wdata_i                      data request (read or write)
//   data_gnt_o / data_rvalid_o /
//   data_rdata_o                      data grant and response
//   mem_req_o / mem_addr_o / mem_we_o /
//   mem_be_o / mem_wdata_o            request to memory
//   mem_gnt_i / mem_rvalid_i /
//   mem_rdata_i                       memory grant and in-order response
module mem_arbiter #(
  parameter int ADDR_WIDTH      = 22,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,

  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,

  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  // One source bit per outstanding transfer: 0 = instr, 1 = data.
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       last_data_q;

  logic full;
  logic empty;
  logic sel_data;
  logic accept;
  logic pop;
  logic head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

  // On a tie the port that did not win the last accepted transfer goes first.
  assign sel_data = data_req_i & (~instr_req_i | ~last_data_q);

  // Full blocks requests outright, even when a response frees a slot this
  // cycle; this keeps mem_req_o off the rvalid-to-req combinational path.
  assign mem_req_o   = (instr_req_i | data_req_i) & ~full & ~rst_i;
  assign accept      = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = accept & ~sel_data;
  assign data_gnt_o  = accept & sel_data;

  // Responses with nothing outstanding (e.g. for transfers dropped by reset)
  // are discarded.
  assign pop            = mem_rvalid_i & ~empty & ~rst_i;
  assign head_id        = id_q[rd_ptr_q];
  assign instr_rvalid_o = pop & ~head_id;
  assign data_rvalid_o  = pop & head_id;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_comb begin
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'hF;
    mem_wdata_o = '0;
    if (sel_data) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_data_q <= 1'b0;
    end else begin
      if (accept) begin
        id_q[wr_ptr_q] <= sel_data;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
        last_data_q    <= sel_data;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i;
  logic [AW-1:0] data_addr_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic port; logic [AW-1:0] addr; } gnt_t;
  typedef struct { logic port; logic [DW-1:0] data; } rsp_t;
  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic push_gnt(input logic port, input logic [AW-1:0] addr);
    gnt_t e;
    e.port = port;
    e.addr = addr;
    exp_gnt.push_back(e);
  endtask

  task automatic push_rsp(input logic port, input logic [DW-1:0] data);
    rsp_t e;
    e.port = port;
    e.data = data;
    exp_rsp.push_back(e);
  endtask

  // Inputs change 1 ns after the rising edge; checks happen before the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'hF;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  // Monitor: every grant and every response is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    gnt_t g;
    rsp_t r;
    if (instr_gnt_o && data_gnt_o) fail_now("both_gnt");
    else if (instr_gnt_o || data_gnt_o) begin
      if (exp_gnt.size() == 0) fail_now("unexpected_gnt");
      else begin
        g = exp_gnt.pop_front();
        chk("gnt_port", 64'(data_gnt_o), 64'(g.port));
        chk("gnt_addr", 64'(mem_addr_o), 64'(g.addr));
      end
    end
    if (instr_rvalid_o && data_rvalid_o) fail_now("both_rvalid");
    else if (instr_rvalid_o || data_rvalid_o) begin
      if (exp_rsp.size() == 0) fail_now("unexpected_rvalid");
      else begin
        r = exp_rsp.pop_front();
        chk("rsp_port", 64'(data_rvalid_o), 64'(r.port));
        chk("rsp_data", 64'(r.port ? data_rdata_o : instr_rdata_o), 64'(r.data));
      end
    end
  end

  initial begin
    // Reset: everything held off even with all inputs active.
    rst_i        = 1'b1;
    idle();
    instr_addr_i = 22'h40;
    data_addr_i  = 22'h80;
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    #3;
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_instr_gnt", 64'(instr_gnt_o), 64'd0);
    chk("rst_data_gnt", 64'(data_gnt_o), 64'd0);
    chk("rst_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'd0);
    step();
    step();
    rst_i = 1'b0;
    idle();

    // Alternating round robin with 1-cycle memory, data wins first tie.
    for (int k = 0; k < 6; k++) begin
      step();
      instr_req_i = 1'b1;
      data_req_i  = 1'b1;
      mem_gnt_i   = 1'b1;
      push_gnt((k % 2) == 0, ((k % 2) == 0) ? 22'h80 : 22'h40);
      if (k > 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1000 + k - 1;
        push_rsp(((k - 1) % 2) == 0, 32'h1000 + k - 1);
      end
    end
    step();
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1005;
    push_rsp(1'b0, 32'h1005);
    step();
    idle();

    // Full: two grants, then blocked, including the cycle a response arrives.
    step();
    instr_addr_i = 22'h44;
    instr_req_i  = 1'b1;
    mem_gnt_i    = 1'b1;
    push_gnt(1'b0, 22'h44);
    step();
    push_gnt(1'b0, 22'h44);
    step();
    #2;
    chk("full_mem_req", 64'(mem_req_o), 64'd0);
    chk("full_gnt", 64'(instr_gnt_o), 64'd0);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h2000;
    push_rsp(1'b0, 32'h2000);
    #2;
    chk("full_pop_mem_req", 64'(mem_req_o), 64'd0);
    chk("full_pop_gnt", 64'(instr_gnt_o), 64'd0);
    chk("full_pop_rvalid", 64'(instr_rvalid_o), 64'd1);
    step();
    mem_rvalid_i = 1'b0;
    push_gnt(1'b0, 22'h44);
    #2;
    chk("after_full_gnt", 64'(instr_gnt_o), 64'd1);
    step();
    instr_req_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h2001;
    push_rsp(1'b0, 32'h2001);
    step();
    mem_rdata_i = 32'h2002;
    push_rsp(1'b0, 32'h2002);
    step();
    idle();

    // Data write payload and its response.
    step();
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_addr_i  = 22'h100;
    data_be_i    = 4'h3;
    data_wdata_i = 32'hDEADBEEF;
    mem_gnt_i    = 1'b1;
    push_gnt(1'b1, 22'h100);
    #2;
    chk("wr_mem_req", 64'(mem_req_o), 64'd1);
    chk("wr_data_gnt", 64'(data_gnt_o), 64'd1);
    chk("wr_instr_gnt", 64'(instr_gnt_o), 64'd0);
    chk("wr_mem_addr", 64'(mem_addr_o), 64'h100);
    chk("wr_mem_we", 64'(mem_we_o), 64'd1);
    chk("wr_mem_be", 64'(mem_be_o), 64'h3);
    chk("wr_mem_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
    step();
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h3000;
    push_rsp(1'b1, 32'h3000);
    #2;
    chk("wr_rsp_data_rvalid", 64'(data_rvalid_o), 64'd1);
    chk("wr_rsp_instr_rvalid", 64'(instr_rvalid_o), 64'd0);
    step();
    idle();

    // Response with nothing outstanding is ignored.
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBAD;
    #2;
    chk("empty_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'd0);
    step();
    idle();

    // Instr at t, data at t+1, memory latency 3.
    step();
    instr_addr_i = 22'h48;
    instr_req_i  = 1'b1;
    mem_gnt_i    = 1'b1;
    push_gnt(1'b0, 22'h48);
    step();
    instr_req_i = 1'b0;
    data_addr_i = 22'h84;
    data_be_i   = 4'hF;
    data_req_i  = 1'b1;
    push_gnt(1'b1, 22'h84);
    step();
    data_req_i = 1'b0;
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h4000;
    push_rsp(1'b0, 32'h4000);
    #2;
    chk("lat_instr_rvalid", 64'(instr_rvalid_o), 64'd1);
    chk("lat_data_rvalid0", 64'(data_rvalid_o), 64'd0);
    chk("lat_instr_rdata", 64'(instr_rdata_o), 64'h4000);
    step();
    mem_rdata_i = 32'h4001;
    push_rsp(1'b1, 32'h4001);
    #2;
    chk("lat_data_rvalid", 64'(data_rvalid_o), 64'd1);
    chk("lat_instr_rvalid0", 64'(instr_rvalid_o), 64'd0);
    chk("lat_data_rdata", 64'(data_rdata_o), 64'h4001);
    step();
    idle();

    // Memory stalls for 5 cycles: request and payload held, nothing granted.
    step();
    instr_addr_i = 22'h4C;
    instr_req_i  = 1'b1;
    data_wdata_i = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      #2;
      chk("stall_mem_req", 64'(mem_req_o), 64'd1);
      chk("stall_mem_addr", 64'(mem_addr_o), 64'h4C);
      chk("stall_mem_be", 64'(mem_be_o), 64'hF);
      chk("stall_mem_wdata", 64'(mem_wdata_o), 64'd0);
      chk("stall_gnt", 64'(instr_gnt_o), 64'd0);
    end
    step();
    mem_gnt_i = 1'b1;
    push_gnt(1'b0, 22'h4C);
    #2;
    chk("stall_release_gnt", 64'(instr_gnt_o), 64'd1);
    step();
    instr_req_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5000;
    push_rsp(1'b0, 32'h5000);
    step();
    mem_rdata_i = 32'h5001;
    #2;
    chk("stall_extra_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'd0);
    step();
    idle();

    // Reset with two outstanding (last grant = data), then stray responses.
    step();
    instr_addr_i = 22'h50;
    instr_req_i  = 1'b1;
    mem_gnt_i    = 1'b1;
    push_gnt(1'b0, 22'h50);
    step();
    instr_req_i = 1'b0;
    data_addr_i = 22'h88;
    data_req_i  = 1'b1;
    push_gnt(1'b1, 22'h88);
    step();
    rst_i       = 1'b1;
    instr_req_i = 1'b1;
    data_req_i  = 1'b1;
    #2;
    chk("midrst_mem_req", 64'(mem_req_o), 64'd0);
    chk("midrst_gnt", 64'({instr_gnt_o, data_gnt_o}), 64'd0);
    step();
    rst_i        = 1'b0;
    idle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h6000;
    #2;
    chk("post_rst_rvalid1", 64'({instr_rvalid_o, data_rvalid_o}), 64'd0);
    step();
    mem_rdata_i = 32'h6001;
    #2;
    chk("post_rst_rvalid2", 64'({instr_rvalid_o, data_rvalid_o}), 64'd0);
    step();
    mem_rvalid_i = 1'b0;
    instr_addr_i = 22'h54;
    data_addr_i  = 22'h8C;
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    mem_gnt_i    = 1'b1;
    push_gnt(1'b1, 22'h8C);
    #2;
    chk("post_rst_tie_data", 64'(data_gnt_o), 64'd1);
    chk("post_rst_tie_instr", 64'(instr_gnt_o), 64'd0);
    step();
    push_gnt(1'b0, 22'h54);
    #2;
    chk("post_rst_second_gnt", 64'(instr_gnt_o), 64'd1);
    step();
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    #2;
    chk("idle_mem_req", 64'(mem_req_o), 64'd0);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h6002;
    push_rsp(1'b1, 32'h6002);
    step();
    mem_rdata_i = 32'h6003;
    push_rsp(1'b0, 32'h6003);
    step();
    idle();
    step();
    step();

    chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
